// File: rtl/fetch_pc_stage_if.sv
//------------------------------------------------------------------------------
// Module  : fetch_pc_stage_if
// Brief   : Program-load, execute feedback and decoded-fetch bundle of the PC stage
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_pc_stage_if;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic        cnd;
  logic [63:0] valM;
  logic [63:0] pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [2:0]  stat;

  modport master (
    output imem_we, imem_waddr, imem_wdata, cnd, valM,
    input  pc, icode, ifun, rA, rB, valC, valP, stat
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata, cnd, valM,
    output pc, icode, ifun, rA, rB, valC, valP, stat
  );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_stage.sv
//------------------------------------------------------------------------------
// Module  : fetch_pc_stage
// Brief   : Y86-64 style fetch: byte-wide instruction memory, decode and PC FSM
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_pc_stage #(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] PC_RESET   = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  fetch_pc_stage_if.slave bus
);

  localparam int          AW       = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [63:0] MEM_SIZE = 64'(IMEM_BYTES);
  localparam logic [2:0]  STAT_AOK = 3'd1;
  localparam logic [2:0]  STAT_HLT = 3'd2;
  localparam logic [2:0]  STAT_ADR = 3'd3;
  localparam logic [2:0]  STAT_INS = 3'd4;

  typedef enum logic [0:0] {RUN = 1'b0, STOPPED = 1'b1} state_t;

  state_t      state, stateNext;
  logic [63:0] pcReg, pcNext;
  logic [2:0]  capStat, capStatNext;

  logic [7:0]  mem [IMEM_BYTES];
  logic [7:0]  fetchBytes [10];
  logic [3:0]  icode, ifun;
  logic        needRegs, insErr, adrErr;
  logic [63:0] instLen, lastAddr, valC, valP;
  logic [2:0]  decStat;

  // Program load is independent of reset so a loaded image survives it.
  always_ff @(posedge clk) begin
    if (bus.imem_we && (bus.imem_waddr < MEM_SIZE)) begin
      mem[bus.imem_waddr[AW-1:0]] <= bus.imem_wdata;
    end
  end

  // Addresses beyond the memory (including wrapped ones) read as zero.
  for (genvar k = 0; k < 10; k++) begin : g_fetchByte
    logic [63:0] byteAddr;
    assign byteAddr      = pcReg + 64'(k);
    assign fetchBytes[k] = (byteAddr < MEM_SIZE) ? mem[byteAddr[AW-1:0]] : 8'h00;
  end

  assign {icode, ifun} = fetchBytes[0];

  always_comb begin
    needRegs = 1'b0;
    instLen  = 64'd1;
    valC     = 64'd0;
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        needRegs = 1'b1;
        instLen  = 64'd2;
      end
      4'h3, 4'h4, 4'h5: begin
        needRegs = 1'b1;
        instLen  = 64'd10;
        valC     = {fetchBytes[9], fetchBytes[8], fetchBytes[7], fetchBytes[6],
                    fetchBytes[5], fetchBytes[4], fetchBytes[3], fetchBytes[2]};
      end
      4'h7, 4'h8: begin
        instLen = 64'd9;
        valC    = {fetchBytes[8], fetchBytes[7], fetchBytes[6], fetchBytes[5],
                   fetchBytes[4], fetchBytes[3], fetchBytes[2], fetchBytes[1]};
      end
      default: ;
    endcase
  end

  always_comb begin
    insErr = 1'b0;
    case (icode)
      4'h2, 4'h7: insErr = (ifun > 4'd6);
      4'h6:       insErr = (ifun > 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                  insErr = (ifun != 4'd0);
      default:    insErr = 1'b1;
    endcase
  end

  assign valP     = pcReg + instLen;
  assign lastAddr = pcReg + instLen - 64'd1;
  assign adrErr   = (pcReg >= MEM_SIZE) || (lastAddr >= MEM_SIZE);

  always_comb begin
    if (adrErr)               decStat = STAT_ADR;
    else if (insErr)          decStat = STAT_INS;
    else if (icode == 4'h0)   decStat = STAT_HLT;
    else                      decStat = STAT_AOK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pcReg   <= PC_RESET;
      capStat <= STAT_AOK;
    end else begin
      state   <= stateNext;
      pcReg   <= pcNext;
      capStat <= capStatNext;
    end
  end

  always_comb begin
    stateNext   = state;
    pcNext      = pcReg;
    capStatNext = capStat;
    if (state == RUN) begin
      if (decStat == STAT_AOK) begin
        case (icode)
          4'h8:    pcNext = valC;
          4'h7:    pcNext = bus.cnd ? valC : valP;
          4'h9:    pcNext = bus.valM;
          default: pcNext = valP;
        endcase
      end else begin
        capStatNext = decStat;
        stateNext   = STOPPED;
      end
    end
  end

  assign bus.pc    = pcReg;
  assign bus.icode = icode;
  assign bus.ifun  = ifun;
  assign bus.rA    = needRegs ? fetchBytes[1][7:4] : 4'hF;
  assign bus.rB    = needRegs ? fetchBytes[1][3:0] : 4'hF;
  assign bus.valC  = valC;
  assign bus.valP  = valP;
  assign bus.stat  = (state == RUN) ? decStat : capStat;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_pc_stage
// Brief   : Self-checking bench: directed table, corner sequences, random programs
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_stage;

  localparam int MEMB = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_stage_if bus ();

  fetch_pc_stage #(.IMEM_BYTES(MEMB), .PC_RESET(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  stat;
  } dec_t;

  typedef struct {
    string       name;
    logic [79:0] prog;
    logic        cnd;
    logic [63:0] valM;
    logic [3:0]  eIcode, eIfun, eRA, eRB;
    logic [63:0] eValC, eValP;
    logic [2:0]  eStat;
    logic [63:0] eNextPc;
  } vec_t;

  // Reference model state
  logic [7:0]  refMem [MEMB];
  logic [63:0] mPc;
  bit          mStopped;
  logic [2:0]  mCap;
  int          lenTab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  logic [7:0]  ops [16] = '{8'h10, 8'h20, 8'h23, 8'h30, 8'h40, 8'h50, 8'h60, 8'h63,
                            8'h70, 8'h74, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'h00, 8'h27};
  vec_t        vecs[$];

  function automatic dec_t refDecode(input logic [63:0] p);
    dec_t        d;
    logic [7:0]  b [10];
    logic [63:0] a;
    int          len, cStart, maxFun;
    bit          ins, adr;
    for (int k = 0; k < 10; k++) begin
      a    = p + 64'(k);
      b[k] = (a < 64'(MEMB)) ? refMem[a[9:0]] : 8'h00;
    end
    d.icode = b[0][7:4];
    d.ifun  = b[0][3:0];
    len     = lenTab[d.icode];
    // register byte present exactly for 2- and 10-byte forms
    d.rA    = (len == 2 || len == 10) ? b[1][7:4] : 4'hF;
    d.rB    = (len == 2 || len == 10) ? b[1][3:0] : 4'hF;
    cStart  = (len == 10) ? 2 : (len == 9) ? 1 : 0;
    d.valC  = 64'd0;
    if (cStart != 0)
      for (int i = 0; i < 8; i++) d.valC = d.valC | (64'(b[cStart + i]) << (8 * i));
    d.valP  = p + 64'(len);
    maxFun  = (d.icode == 2 || d.icode == 7) ? 6 : (d.icode == 6) ? 3 : 0;
    ins     = (d.icode > 11) || (int'(d.ifun) > maxFun);
    adr     = (p >= 64'(MEMB)) || ((p + 64'(len) - 64'd1) >= 64'(MEMB));
    d.stat  = adr ? 3'd3 : ins ? 3'd4 : (d.icode == 0) ? 3'd2 : 3'd1;
    return d;
  endfunction

  function automatic vec_t mk(input string n, input logic [79:0] pr, input logic c,
                              input logic [63:0] vm, input logic [3:0] ic, fn, ra, rb,
                              input logic [63:0] vc, vp, input logic [2:0] st,
                              input logic [63:0] np);
    vec_t v;
    v.name = n; v.prog = pr; v.cnd = c; v.valM = vm;
    v.eIcode = ic; v.eIfun = fn; v.eRA = ra; v.eRB = rb;
    v.eValC = vc; v.eValP = vp; v.eStat = st; v.eNextPc = np;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 64'h0; mStopped = 1'b0; mCap = 3'd1;
  endtask

  task automatic modelStep(input logic c, input logic [63:0] vm);
    dec_t d;
    if (!mStopped) begin
      d = refDecode(mPc);
      if (d.stat == 3'd1) begin
        if (d.icode == 4'h8 || (d.icode == 4'h7 && c)) mPc = d.valC;
        else if (d.icode == 4'h9)                       mPc = vm;
        else                                            mPc = d.valP;
      end else begin
        mStopped = 1'b1;
        mCap     = d.stat;
      end
    end
  endtask

  // Advance one clock: model sees pre-edge memory, then the pending write lands.
  task automatic tick();
    if (!reset) modelStep(bus.cnd, bus.valM);
    if (bus.imem_we && bus.imem_waddr < 64'(MEMB)) refMem[bus.imem_waddr[9:0]] = bus.imem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic writeByte(input logic [63:0] a, input logic [7:0] d);
    bus.imem_we = 1'b1; bus.imem_waddr = a; bus.imem_wdata = d;
    tick();
    bus.imem_we = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    modelReset();
  endtask

  task automatic checkModel(input string tag);
    dec_t d;
    d = refDecode(mPc);
    check({tag, ".pc"},    bus.pc,    mPc);
    check({tag, ".stat"},  64'(bus.stat), mStopped ? 64'(mCap) : 64'(d.stat));
    check({tag, ".icode"}, 64'(bus.icode), 64'(d.icode));
    check({tag, ".ifun"},  64'(bus.ifun),  64'(d.ifun));
    check({tag, ".rA"},    64'(bus.rA),    64'(d.rA));
    check({tag, ".rB"},    64'(bus.rB),    64'(d.rB));
    check({tag, ".valC"},  bus.valC,  d.valC);
    check({tag, ".valP"},  bus.valP,  d.valP);
  endtask

  initial begin
    vec_t v;
    logic [7:0] rb;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
    bus.cnd = 1'b0; bus.valM = '0;
    modelReset();

    for (int i = 0; i < MEMB; i++) writeByte(64'(i), 8'h00);
    check("reset.pc",   bus.pc, 64'h0);
    check("reset.stat", 64'(bus.stat), 64'd2);

    vecs.push_back(mk("irmovq",  80'h30F30800000000000000, 0, 0,     4'h3, 4'h0, 4'hF, 4'h3, 64'h8, 64'd10, 3'd1, 64'd10));
    vecs.push_back(mk("jle_nt",  80'h73200000000000000000, 0, 0,     4'h7, 4'h3, 4'hF, 4'hF, 64'h20, 64'd9, 3'd1, 64'd9));
    vecs.push_back(mk("jle_t",   80'h73200000000000000000, 1, 0,     4'h7, 4'h3, 4'hF, 4'hF, 64'h20, 64'd9, 3'd1, 64'h20));
    vecs.push_back(mk("ret",     80'h90000000000000000000, 0, 64'h40, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 3'd1, 64'h40));
    vecs.push_back(mk("call",    80'h80180000000000000000, 0, 0,     4'h8, 4'h0, 4'hF, 4'hF, 64'h18, 64'd9, 3'd1, 64'h18));
    vecs.push_back(mk("cmov_bad",80'h27000000000000000000, 0, 0,     4'h2, 4'h7, 4'h0, 4'h0, 64'h0, 64'd2, 3'd4, 64'h0));
    vecs.push_back(mk("halt",    80'h00000000000000000000, 0, 0,     4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 3'd2, 64'h0));
    vecs.push_back(mk("nop",     80'h10000000000000000000, 0, 0,     4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 3'd1, 64'd1));
    vecs.push_back(mk("addq",    80'h60120000000000000000, 0, 0,     4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'd2, 3'd1, 64'd2));
    vecs.push_back(mk("opq_bad", 80'h64120000000000000000, 0, 0,     4'h6, 4'h4, 4'h1, 4'h2, 64'h0, 64'd2, 3'd4, 64'h0));
    vecs.push_back(mk("icode_c", 80'hC0000000000000000000, 0, 0,     4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 3'd4, 64'h0));
    vecs.push_back(mk("rmmovq",  80'h40128877665544332211, 0, 0,     4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 64'd10, 3'd1, 64'd10));
    vecs.push_back(mk("pushq",   80'hA03F0000000000000000, 0, 0,     4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'd2, 3'd1, 64'd2));
    vecs.push_back(mk("nop_bad", 80'h11000000000000000000, 0, 0,     4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'd1, 3'd4, 64'h0));
    vecs.push_back(mk("jne_t",   80'h74400000000000000000, 1, 0,     4'h7, 4'h4, 4'hF, 4'hF, 64'h40, 64'd9, 3'd1, 64'h40));
    vecs.push_back(mk("mrmovq",  80'h50450100000000000000, 0, 0,     4'h5, 4'h0, 4'h4, 4'h5, 64'h1, 64'd10, 3'd1, 64'd10));

    foreach (vecs[n]) begin
      v = vecs[n];
      doReset();
      for (int k = 0; k < 10; k++) begin
        rb = v.prog[79 - 8 * k -: 8];
        writeByte(64'(k), rb);
      end
      bus.cnd = v.cnd; bus.valM = v.valM;
      reset = 1'b0;
      #1;
      check({v.name, ".pc"},    bus.pc, 64'h0);
      check({v.name, ".icode"}, 64'(bus.icode), 64'(v.eIcode));
      check({v.name, ".ifun"},  64'(bus.ifun),  64'(v.eIfun));
      check({v.name, ".stat"},  64'(bus.stat),  64'(v.eStat));
      if (v.eStat != 3'd4) begin
        check({v.name, ".rA"},   64'(bus.rA), 64'(v.eRA));
        check({v.name, ".rB"},   64'(bus.rB), 64'(v.eRB));
        check({v.name, ".valC"}, bus.valC, v.eValC);
        check({v.name, ".valP"}, bus.valP, v.eValP);
      end
      tick();
      check({v.name, ".nextPc"}, bus.pc, v.eNextPc);
      check({v.name, ".nextStat"}, 64'(bus.stat),
            (v.eStat != 3'd1) ? 64'(v.eStat) : 64'(refDecode(v.eNextPc).stat));
    end

    // irmovq, nop, halt, then sticky HLT
    doReset();
    for (int k = 0; k < 10; k++) writeByte(64'(k), (k == 0) ? 8'h30 : (k == 1) ? 8'hF3 : (k == 2) ? 8'h08 : 8'h00);
    writeByte(64'd10, 8'h10);
    writeByte(64'd11, 8'h00);
    bus.cnd = 1'b0;
    reset = 1'b0;
    #1;
    check("seq1.pc0",   bus.pc, 64'd0);
    check("seq1.rB",    64'(bus.rB), 64'h3);
    check("seq1.valC",  bus.valC, 64'd8);
    check("seq1.valP",  bus.valP, 64'd10);
    tick();
    check("seq1.pc10",  bus.pc, 64'd10);
    check("seq1.stat10", 64'(bus.stat), 64'd1);
    tick();
    check("seq1.pc11",  bus.pc, 64'd11);
    check("seq1.stat11", 64'(bus.stat), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq1.holdPc",   bus.pc, 64'd11);
      check("seq1.holdStat", 64'(bus.stat), 64'd2);
    end

    // jump to an instruction straddling the end of memory, edit it while stopped
    doReset();
    for (int k = 0; k < 10; k++) writeByte(64'(k), (k == 0) ? 8'h70 : (k == 1) ? 8'hFC : (k == 2) ? 8'h03 : 8'h00);
    writeByte(64'd1020, 8'h30); writeByte(64'd1021, 8'hF3);
    writeByte(64'd1022, 8'h08); writeByte(64'd1023, 8'h00);
    writeByte(64'd1024, 8'h00);
    writeByte(64'hFFFF_FFFF_FFFF_FC00, 8'h00);
    check("oorWrite.icode", 64'(bus.icode), 64'h7);
    bus.cnd = 1'b1;
    reset = 1'b0;
    #1;
    check("seq2.stat0", 64'(bus.stat), 64'd1);
    tick();
    check("seq2.pc",    bus.pc, 64'd1020);
    check("seq2.stat",  64'(bus.stat), 64'd3);
    tick();
    check("seq2.holdPc", bus.pc, 64'd1020);
    writeByte(64'd1020, 8'h10);
    check("seq2.liveIcode", 64'(bus.icode), 64'h1);
    check("seq2.stickyStat", 64'(bus.stat), 64'd3);
    check("seq2.frozenPc", bus.pc, 64'd1020);
    #2;
    reset = 1'b1;
    #1;
    check("asyncRst.pc",   bus.pc, 64'd0);
    check("asyncRst.stat", 64'(bus.stat), 64'd1);
    modelReset();

    // jump to the first byte past memory
    writeByte(64'd1, 8'h00);
    writeByte(64'd2, 8'h04);
    reset = 1'b0;
    tick();
    check("pastEnd.pc",    bus.pc, 64'h400);
    check("pastEnd.stat",  64'(bus.stat), 64'd3);
    check("pastEnd.icode", {56'd0, bus.icode, bus.ifun}, 64'h0);
    tick();
    check("pastEnd.hold",  bus.pc, 64'h400);

    // random programs with live memory edits against the model
    for (int t = 0; t < 30; t++) begin
      doReset();
      for (int a = 0; a < 48; a++) begin
        case ($urandom_range(0, 3))
          0, 1:    rb = ops[$urandom_range(0, 15)];
          2:       rb = 8'h00;
          default: rb = 8'($urandom_range(0, 48));
        endcase
        writeByte(64'(a), rb);
      end
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
        bus.cnd  = 1'($urandom_range(0, 1));
        bus.valM = ($urandom_range(0, 7) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 48));
        if ($urandom_range(0, 3) == 0) begin
          bus.imem_we    = 1'b1;
          bus.imem_waddr = ($urandom_range(0, 7) == 0) ? 64'(1024 + $urandom_range(0, 9)) : 64'($urandom_range(0, 49));
          bus.imem_wdata = ops[$urandom_range(0, 15)];
        end
        #1;
        checkModel($sformatf("rnd%0d.c%0d", t, c));
        tick();
        bus.imem_we = 1'b0;
      end
      checkModel($sformatf("rnd%0d.end", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_pc_stage.md
FETCH_PC_STAGE -- requirements
Module: fetch_pc_stage

Interface
REQ-001 Parameter IMEM_BYTES, default 1024, instruction-memory size in bytes.
REQ-002 Parameter PC_RESET, default 64'h0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_we  input  1  program-load byte write enable.
REQ-006 imem_waddr  input  64  program-load byte address.
REQ-007 imem_wdata  input  8  program-load byte data.
REQ-008 cnd  input  1  branch condition from execute, valid for the current instruction.
REQ-009 valM  input  64  memory read data (return address for ret).
REQ-010 pc  output  64  current PC.
REQ-011 icode  output  4  instruction code.
REQ-012 ifun  output  4  function code.
REQ-013 rA  output  4  register specifier A (4'hF if none).
REQ-014 rB  output  4  register specifier B (4'hF if none).
REQ-015 valC  output  64  constant word, little-endian (0 if none).
REQ-016 valP  output  64  address of next sequential instruction.
REQ-017 stat  output  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS.

Function
REQ-018 The instruction memory SHALL be a byte array of IMEM_BYTES bytes; a write on rising edge with imem_we=1 and imem_waddr<IMEM_BYTES SHALL store imem_wdata; out-of-range writes are ignored; writes are allowed in every state.
REQ-019 Fetch decode SHALL be combinational from pc and memory contents: byte0 = {icode,ifun}; byte1 = {rA,rB} when regids needed; valC = next 8 bytes, least significant first.
REQ-020 Lengths SHALL be: halt/nop/ret (0,1,9) 1 byte; cmovXX/OPq/pushq/popq (2,6,A,B) 2 bytes; jXX/call (7,8) 9 bytes; irmovq/rmmovq/mrmovq (3,4,5) 10 bytes; valP = pc + length.
REQ-021 valC SHALL start at pc+2 for icodes 3,4,5 and at pc+1 for icodes 7,8.
REQ-022 The instruction SHALL be invalid when icode > B, or ifun > 6 for icodes 2 or 7, or ifun > 3 for icode 6, or ifun != 0 for any other icode.
REQ-023 Address error SHALL be flagged when pc + length - 1 >= IMEM_BYTES, or pc >= IMEM_BYTES; on pc >= IMEM_BYTES, icode/ifun SHALL read as 0.
REQ-024 Decoded status SHALL have priority ADR > INS > HLT (icode 0) > AOK.
REQ-025 The FSM SHALL have two states: RUN and STOPPED.
REQ-026 In RUN, stat SHALL equal the decoded status of the instruction at pc.
REQ-027 In RUN with decoded status AOK, the rising edge SHALL load pc with: valC for call; valC for jXX when cnd=1; valM for ret; valP otherwise.
REQ-028 In RUN with decoded status not AOK, the rising edge SHALL capture that status into a sticky register, hold pc, and enter STOPPED.
REQ-029 In STOPPED, pc SHALL be frozen and stat SHALL output the captured status; decode outputs continue to reflect pc.
REQ-030 STOPPED SHALL be exited only by reset.
REQ-031 PC arithmetic SHALL be 64-bit unsigned with wrap-around; wrapped addresses fall under REQ-023.
REQ-032 A program-load write to bytes of the current instruction SHALL take effect in the decode outputs after that edge and SHALL NOT stall the FSM.

Reset
REQ-033 Asserting reset SHALL immediately force pc=PC_RESET, state=RUN and captured status=AOK, regardless of clk.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 Reset deasserted mid-program SHALL restart fetch at PC_RESET on the next rising edge.

Verification
REQ-036 Load 30 F3 08 00 00 00 00 00 00 00 at 0, then 10, 00; release reset -> pc=0, icode=3, rA=F, rB=3, valC=8, valP=10; next edge pc=10 (nop); next edge pc=11, stat=2; then stays STOPPED.
REQ-037 Bytes 73 20 00 00 00 00 00 00 00 at 0 with cnd=0 -> next pc=9; repeat with cnd=1 -> next pc=32.
REQ-038 Byte 90 at 0 with valM=64'h40 -> next pc=0x40; call 80 18 00.. -> next pc=0x18, valP=9.
REQ-039 Byte 27 (cmov, ifun 7) at 0 -> stat=4 on the same cycle; after the edge STOPPED, pc=0, stat=4 held.
REQ-040 IMEM_BYTES=1024, 3-byte-length-10 instruction at pc=1020 -> stat=3, pc frozen at 1020.
REQ-041 Assert reset asynchronously while STOPPED -> pc=0, stat=decoded AOK without waiting for a clock edge.
